// File: rtl/otter_pkg.sv
// Shared OTTER core definitions: pc_source encoding, redirect squash states and reset PC.
package otter_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [2:0] {
      PC_PLUS4  = 3'd0,
      PC_JALR   = 3'd1,
      PC_BRANCH = 3'd2,
      PC_JAL    = 3'd3,
      PC_MTVEC  = 3'd4,
      PC_MEPC   = 3'd5
   } pcsrc_t;

   typedef enum logic [1:0] {
      SQ_RUN    = 2'd0,
      SQ_HOLD   = 2'd1,
      SQ_ACTIVE = 2'd2
   } squash_state_t;

endpackage

// File: rtl/pc_target_mux.sv
// Redirect target select for the fetch PC; jalr targets are halfword-aligned by clearing bit 0.
module pc_target_mux
   import otter_pkg::*;
(
   input  logic [2:0]  pc_source,
   input  logic [31:0] jalr_target,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic [31:0] target
);

   always_comb begin
      target = '0;
      case (pc_source)
         PC_JALR:   target = {jalr_target[31:1], 1'b0};
         PC_BRANCH: target = branch_target;
         PC_JAL:    target = jal_target;
         PC_MTVEC:  target = mtvec;
         PC_MEPC:   target = mepc;
         default:   target = '0;
      endcase
   end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: applies each EX redirect once, buffers it while imem is busy,
// and raises squash_ex for the wrong-path instructions that follow into EX.
module pc_redirect_unit
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          SQUASH_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [2:0]  pc_source,
   input  logic [31:0] jalr_target,
   input  logic [31:0] branch_target,
   input  logic [31:0] jal_target,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic        stall_ex,
   input  logic        stall_if,
   input  logic        imem_ready,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic        squash_ex,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        redirect_pending,
   output logic [1:0]  squash_state
);

   localparam logic [3:0] SQ_LOAD = 4'(SQUASH_DEPTH - 1);

   squash_state_t state, state_nxt;
   logic [3:0]    sq_cnt, sq_cnt_nxt;
   logic [31:0]   target;
   logic [31:0]   pending_target;
   logic          redirect_req;
   logic          accept;

   pc_target_mux u_target_mux (
      .pc_source     (pc_source),
      .jalr_target   (jalr_target),
      .branch_target (branch_target),
      .jal_target    (jal_target),
      .mtvec         (mtvec),
      .mepc          (mepc),
      .target        (target)
   );

   // Reserved codes 6/7 fall outside this range and behave as PC+4.
   assign redirect_req = (pc_source >= PC_JALR) && (pc_source <= PC_MEPC);
   assign accept       = redirect_req && (state == SQ_RUN) && !squash_ex;
   assign flush_if_id  = accept;
   assign flush_id_ex  = accept;
   assign pc_plus4     = pc + 32'd4;
   assign squash_state = state;

   always_comb begin
      state_nxt  = state;
      sq_cnt_nxt = sq_cnt;
      case (state)
         SQ_RUN: begin
            if (accept) begin
               if (stall_ex) begin
                  state_nxt = SQ_HOLD;
               end else begin
                  state_nxt  = (SQUASH_DEPTH == 0) ? SQ_RUN : SQ_ACTIVE;
                  sq_cnt_nxt = SQ_LOAD;
               end
            end
         end
         SQ_HOLD: begin
            if (!stall_ex) begin
               state_nxt  = (SQUASH_DEPTH == 0) ? SQ_RUN : SQ_ACTIVE;
               sq_cnt_nxt = SQ_LOAD;
            end
         end
         SQ_ACTIVE: begin
            if (!stall_ex) begin
               if (sq_cnt == 4'd0) state_nxt = SQ_RUN;
               else                sq_cnt_nxt = sq_cnt - 4'd1;
            end
         end
         default: state_nxt = SQ_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= SQ_RUN;
         sq_cnt    <= '0;
         squash_ex <= 1'b0;
      end else begin
         state     <= state_nxt;
         sq_cnt    <= sq_cnt_nxt;
         squash_ex <= (state_nxt == SQ_ACTIVE);
      end
   end

   // imem_ready qualifies every PC update; imem_req stays high outside reset so
   // the memory always sees a live request. A pending redirect overrides stall_if.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc               <= RESET_VECTOR;
         pending_target   <= '0;
         redirect_pending <= 1'b0;
         imem_req         <= 1'b0;
      end else begin
         imem_req <= 1'b1;
         if (accept) begin
            if (imem_ready) begin
               pc               <= target;
               redirect_pending <= 1'b0;
            end else begin
               pending_target   <= target;
               redirect_pending <= 1'b1;
            end
         end else if (redirect_pending) begin
            if (imem_ready) begin
               pc               <= pending_target;
               redirect_pending <= 1'b0;
            end
         end else if (imem_ready && !stall_if) begin
            pc <= pc_plus4;
         end
      end
   end

endmodule
